// File: rtl/csr_intr_unit.sv
// Machine-mode CSR file (mstatus/mie/mtvec/mepc/mcause/mip) with
// synchronized external-interrupt latch and one-cycle trap pulse.
module csr_intr_unit (
   input  logic        CLK,
   input  logic        RST,
   input  logic        INTR_IN,
   input  logic        INSTR_DONE,
   input  logic        CSR_WE,
   input  logic [11:0] CSR_ADDR,
   input  logic [2:0]  CSR_FUNC3,
   input  logic [31:0] CSR_WD,
   input  logic        MRET,
   input  logic [31:0] PC,
   output logic [31:0] CSR_RD,
   output logic        INTR_TAKEN,
   output logic [31:0] MTVEC,
   output logic [31:0] MEPC,
   output logic        MIE_BIT
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MIP     = 12'h344;

   typedef enum logic {RUN, TRAP} state_t;

   state_t      state, state_n;
   logic        mie_r, mpie_r, meie_r;
   logic        mie_n, mpie_n, meie_n;
   logic [31:0] mtvec_r, mepc_r, mcause_r;
   logic        pending;
   logic        s1, s2, s3;
   logic        edge_det;
   logic        do_wr;
   logic        take;
   logic [31:0] wval;
   logic        unused_bits;

   assign unused_bits = ^{CSR_FUNC3[2], PC[1:0]};
   assign edge_det    = s2 & ~s3;

   always_comb begin
      CSR_RD = '0;
      case (CSR_ADDR)
         ADDR_MSTATUS: CSR_RD = {24'd0, mpie_r, 3'd0, mie_r, 3'd0};
         ADDR_MIE:     CSR_RD = {20'd0, meie_r, 11'd0};
         ADDR_MTVEC:   CSR_RD = mtvec_r;
         ADDR_MEPC:    CSR_RD = mepc_r;
         ADDR_MCAUSE:  CSR_RD = mcause_r;
         ADDR_MIP:     CSR_RD = {20'd0, pending, 11'd0};
         default:      CSR_RD = '0;
      endcase
   end

   always_comb begin
      wval = CSR_RD;
      case (CSR_FUNC3[1:0])
         2'b01:   wval = CSR_WD;
         2'b10:   wval = CSR_RD | CSR_WD;
         2'b11:   wval = CSR_RD & ~CSR_WD;
         default: wval = CSR_RD;
      endcase
   end

   assign do_wr = CSR_WE && (state == RUN) && (CSR_FUNC3[1:0] != 2'b00);

   // Post-write / post-MRET enables; the take decision must see them
   always_comb begin
      mie_n  = mie_r;
      mpie_n = mpie_r;
      meie_n = meie_r;
      if (do_wr && CSR_ADDR == ADDR_MSTATUS) begin
         mie_n  = wval[3];
         mpie_n = wval[7];
      end
      if (do_wr && CSR_ADDR == ADDR_MIE)
         meie_n = wval[11];
      if (MRET && state == RUN) begin
         mie_n  = mpie_r;
         mpie_n = 1'b1;
      end
   end

   always_comb begin
      take    = (state == RUN) && INSTR_DONE && pending && mie_n && meie_n;
      state_n = state;
      case (state)
         RUN:     if (take) state_n = TRAP;
         TRAP:    state_n = RUN;
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= RUN;
         s1       <= 1'b0;
         s2       <= 1'b0;
         s3       <= 1'b0;
         pending  <= 1'b0;
         mie_r    <= 1'b0;
         mpie_r   <= 1'b0;
         meie_r   <= 1'b0;
         mtvec_r  <= '0;
         mepc_r   <= '0;
         mcause_r <= '0;
      end else begin
         state   <= state_n;
         s1      <= INTR_IN;
         s2      <= s1;
         s3      <= s2;
         // A fresh edge in the trap cycle outranks the clear
         pending <= edge_det | (pending & (state != TRAP));
         if (state == TRAP) begin
            mepc_r   <= {PC[31:2], 2'b00};
            mcause_r <= 32'h8000_000B;
            mpie_r   <= mie_r;
            mie_r    <= 1'b0;
         end else begin
            mie_r  <= mie_n;
            mpie_r <= mpie_n;
            meie_r <= meie_n;
            if (do_wr) begin
               case (CSR_ADDR)
                  ADDR_MTVEC:  mtvec_r  <= {wval[31:2], 2'b00};
                  ADDR_MEPC:   mepc_r   <= {wval[31:2], 2'b00};
                  ADDR_MCAUSE: mcause_r <= wval;
                  default:     ;
               endcase
            end
         end
      end
   end

   assign INTR_TAKEN = (state == TRAP);
   assign MTVEC      = mtvec_r;
   assign MEPC       = mepc_r;
   assign MIE_BIT    = mie_r;

endmodule
